// File: rtl/rv32_csr_pkg.sv
// rtl/rv32_csr_pkg.sv - shared types and constants for the rv32 CSR execute unit
package rv32_csr_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'b001,
        CSR_OP_RS  = 3'b010,
        CSR_OP_RC  = 3'b011,
        CSR_OP_RWI = 3'b101,
        CSR_OP_RSI = 3'b110,
        CSR_OP_RCI = 3'b111
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;
    localparam int         F3_IMM_BIT = 2;

    localparam int CSR_PERM_HI = 11;
    localparam int CSR_PERM_LO = 10;
    localparam int CSR_PRIV_HI = 9;
    localparam int CSR_PRIV_LO = 8;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;
    localparam logic [1:0] PERM_RO = 2'b11;

endpackage

// File: rtl/rv32_csr_legal_check.sv
// rtl/rv32_csr_legal_check.sv - combinational CSR legality and write-required decode
module rv32_csr_legal_check
    import rv32_csr_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [3:0] i_addr_hi,
    input  logic [4:0] i_rs1_idx,
    input  logic [1:0] i_priviledge,
    output logic       o_write_req,
    output logic       o_illegal
);

    logic w_bad_funct3;
    logic w_priv_low;
    logic w_ro_write;

    // Set/clear forms only write when the source register/immediate field is nonzero.
    assign o_write_req  = (i_funct3[1:0] == F3_CSRRW[1:0]) || (i_rs1_idx != 5'd0);
    assign w_bad_funct3 = (i_funct3[1:0] == 2'b00);
    assign w_priv_low   = (i_addr_hi[CSR_PRIV_HI-8:CSR_PRIV_LO-8] > i_priviledge);
    assign w_ro_write   = (i_addr_hi[CSR_PERM_HI-8:CSR_PERM_LO-8] == PERM_RO) && o_write_req;
    assign o_illegal    = w_bad_funct3 || w_priv_low || w_ro_write;

endmodule

// File: rtl/rv32_csr_exec.sv
// rtl/rv32_csr_exec.sv - execute-stage CSR read-modify-write unit
// Optional perf counters enabled by defining RV32_CSR_PERF_COUNT_EN.
module rv32_csr_exec
    import rv32_csr_pkg::*;
#(
    parameter int READ_LATENCY = 0,
    parameter int XLEN         = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_priviledge,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [11:0]     i_req_csr_addr,
    input  logic [XLEN-1:0] i_req_rs1_data,
    input  logic [4:0]      i_req_rs1_idx,
    input  logic [4:0]      i_req_rd_idx,
    output logic [11:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_csr_we,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [4:0]      o_resp_rd_idx,
    output logic [XLEN-1:0] o_resp_rd_data,
`ifdef RV32_CSR_PERF_COUNT_EN
    output logic [31:0]     o_perf_csr_ops,
    output logic [31:0]     o_perf_illegal,
`endif
    output logic            o_resp_illegal
);

    localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    csr_state_e      r_state;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rs1_idx;
    logic [XLEN-1:0] r_rs1_data;
    logic            r_wr_req;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_csr_we;
    logic [4:0]      r_rd_idx;
    logic [XLEN-1:0] r_rd_data;
    logic            r_illegal;
`ifdef RV32_CSR_PERF_COUNT_EN
    logic [31:0]     r_perf_ops;
    logic [31:0]     r_perf_ill;
`endif

    logic            w_write_req;
    logic            w_illegal;
    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_wdata;
    csr_op_e         w_op;

    rv32_csr_legal_check u_legal (
        .i_funct3     (i_req_funct3),
        .i_addr_hi    (i_req_csr_addr[CSR_PERM_HI:CSR_PRIV_LO]),
        .i_rs1_idx    (i_req_rs1_idx),
        .i_priviledge (i_priviledge),
        .o_write_req  (w_write_req),
        .o_illegal    (w_illegal)
    );

    assign w_op  = csr_op_e'(r_funct3);
    assign w_src = r_funct3[F3_IMM_BIT] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_data;

    // Old value comes straight from the CSR file on the last READ cycle.
    always_comb begin
        w_wdata = w_src;
        case (w_op)
            CSR_OP_RS, CSR_OP_RSI: w_wdata = i_csr_rdata | w_src;
            CSR_OP_RC, CSR_OP_RCI: w_wdata = i_csr_rdata & ~w_src;
            default:               w_wdata = w_src;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= '0;
            r_funct3    <= '0;
            r_rs1_idx   <= '0;
            r_rs1_data  <= '0;
            r_wr_req    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            r_csr_we    <= 1'b0;
            r_rd_idx    <= '0;
            r_rd_data   <= '0;
            r_illegal   <= 1'b0;
`ifdef RV32_CSR_PERF_COUNT_EN
            r_perf_ops  <= '0;
            r_perf_ill  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_funct3   <= i_req_funct3;
                        r_rs1_idx  <= i_req_rs1_idx;
                        r_rs1_data <= i_req_rs1_data;
                        r_rd_idx   <= i_req_rd_idx;
                        r_wr_req   <= w_write_req;
                        r_lat_cnt  <= '0;
                        r_illegal  <= w_illegal;
                        if (w_illegal) begin
                            r_rd_data <= '0;
                            r_state   <= ST_RESP;
                        end else begin
                            r_csr_addr <= i_req_csr_addr;
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_lat_cnt == CNT_W'(READ_LATENCY)) begin
                        r_rd_data   <= i_csr_rdata;
                        r_csr_wdata <= w_wdata;
                        if (r_wr_req) begin
                            r_csr_we <= 1'b1;
                            r_state  <= ST_WRITE;
                        end else begin
                            r_state  <= ST_RESP;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + CNT_W'(1);
                    end
                end
                ST_WRITE: begin
                    r_csr_we <= 1'b0;
                    r_state  <= ST_RESP;
                end
                default: begin
                    if (i_resp_ready) begin
                        r_csr_addr  <= '0;
                        r_csr_wdata <= '0;
                        r_state     <= ST_IDLE;
`ifdef RV32_CSR_PERF_COUNT_EN
                        if (r_illegal) r_perf_ill <= r_perf_ill + 32'd1;
                        else           r_perf_ops <= r_perf_ops + 32'd1;
`endif
                    end
                end
            endcase
        end
    end

    assign o_req_ready    = (r_state == ST_IDLE);
    assign o_resp_valid   = (r_state == ST_RESP);
    assign o_csr_addr     = r_csr_addr;
    assign o_csr_wdata    = r_csr_wdata;
    assign o_csr_we       = r_csr_we;
    assign o_resp_rd_idx  = r_rd_idx;
    assign o_resp_rd_data = r_rd_data;
    assign o_resp_illegal = r_illegal;
`ifdef RV32_CSR_PERF_COUNT_EN
    assign o_perf_csr_ops = r_perf_ops;
    assign o_perf_illegal = r_perf_ill;
`endif

endmodule

// File: tb/tb_rv32_csr_exec.sv
// tb/tb_rv32_csr_exec.sv - self-checking bench for rv32_csr_exec at READ_LATENCY 0 and 1
module tb_rv32_csr_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  priv       [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [2:0]  req_funct3 [2];
    logic [11:0] req_addr   [2];
    logic [31:0] req_rs1    [2];
    logic [4:0]  req_idx    [2];
    logic [4:0]  req_rd     [2];
    logic [11:0] csr_addr   [2];
    logic [31:0] csr_wdata  [2];
    logic        csr_we     [2];
    logic [31:0] csr_rdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [4:0]  resp_rd    [2];
    logic [31:0] resp_data  [2];
    logic        resp_ill   [2];
`ifdef RV32_CSR_PERF_COUNT_EN
    logic [31:0] perf_ops   [2];
    logic [31:0] perf_ill   [2];
    int          exp_ops    [2];
    int          exp_ill    [2];
`endif

    logic [11:0] exp_addr [2];
    logic [31:0] csr_val  [2];
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rv32_csr_exec #(.READ_LATENCY(g), .XLEN(32)) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_priviledge   (priv[g]),
            .i_req_valid    (req_valid[g]),
            .o_req_ready    (req_ready[g]),
            .i_req_funct3   (req_funct3[g]),
            .i_req_csr_addr (req_addr[g]),
            .i_req_rs1_data (req_rs1[g]),
            .i_req_rs1_idx  (req_idx[g]),
            .i_req_rd_idx   (req_rd[g]),
            .o_csr_addr     (csr_addr[g]),
            .o_csr_wdata    (csr_wdata[g]),
            .o_csr_we       (csr_we[g]),
            .i_csr_rdata    (csr_rdata[g]),
            .o_resp_valid   (resp_valid[g]),
            .i_resp_ready   (resp_ready[g]),
            .o_resp_rd_idx  (resp_rd[g]),
            .o_resp_rd_data (resp_data[g]),
`ifdef RV32_CSR_PERF_COUNT_EN
            .o_perf_csr_ops (perf_ops[g]),
            .o_perf_illegal (perf_ill[g]),
`endif
            .o_resp_illegal (resp_ill[g])
        );
    end

    // CSR file: returns the preloaded value only at the expected address.
    assign csr_rdata[0] = (csr_addr[0] == exp_addr[0]) ? csr_val[0] : 32'hBAD0BAD0;
    always @(posedge clk)
        csr_rdata[1] <= (csr_addr[1] == exp_addr[1]) ? csr_val[1] : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] f3, input logic [11:0] addr,
                                  input logic [1:0] pv, input logic [4:0] idx,
                                  input logic [31:0] rs1, input logic [31:0] old,
                                  output bit ill, output bit wr, output logic [31:0] wd);
        logic [31:0] src;
        wr  = (f3 == 3'd1) || (f3 == 3'd5) || (idx != 0);
        ill = (f3 == 3'd0) || (f3 == 3'd4) || (int'(addr[9:8]) > int'(pv))
              || ((addr[11:10] == 2'b11) && wr);
        src = (f3 >= 3'd4) ? 32'(idx) : rs1;
        case (f3 % 4)
            2:       wd = old | src;
            3:       wd = old & ~src;
            default: wd = src;
        endcase
    endfunction

    task automatic run_op(input int d, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [1:0] pv, input logic [4:0] idx, input logic [31:0] rs1,
                          input logic [4:0] rd, input logic [31:0] old, input int hold);
        bit ill, wr, got, bad;
        logic [31:0] ewd, wd, d0;
        logic [11:0] wa;
        int n, we_n, elat;
        model(f3, addr, pv, idx, rs1, old, ill, wr, ewd);
        elat = ill ? 1 : ((wr ? 3 : 2) + d);
        @(negedge clk);
        exp_addr[d] = addr; csr_val[d] = old; priv[d] = pv;
        req_funct3[d] = f3; req_addr[d] = addr; req_rs1[d] = rs1;
        req_idx[d] = idx; req_rd[d] = rd; req_valid[d] = 1'b1;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1 req_valid[d] = 1'b0;
        n = 0; got = 0; we_n = 0; bad = 0; wd = 0; wa = 0;
        while (!got && n < 30) begin
            @(negedge clk); n++;
            if (csr_we[d]) begin we_n++; wd = csr_wdata[d]; wa = csr_addr[d]; end
            if (resp_valid[d]) got = 1;
            else if (req_ready[d]) bad = 1;
        end
        chk("resp_latency", 32'(n), 32'(elat));
        chk("busy_no_ready", 32'(bad), 32'd0);
        chk("rd_data", resp_data[d], ill ? 32'd0 : old);
        chk("illegal", 32'(resp_ill[d]), 32'(ill));
        chk("rd_idx", 32'(resp_rd[d]), 32'(rd));
        chk("we_pulses", 32'(we_n), (!ill && wr) ? 32'd1 : 32'd0);
        if (!ill && wr) begin
            chk("wdata", wd, ewd);
            chk("waddr", 32'(wa), 32'(addr));
        end
        d0 = resp_data[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid[d] || resp_data[d] !== d0 || resp_ill[d] !== ill
                || resp_rd[d] !== rd || req_ready[d] || csr_we[d]) bad = 1;
        end
        if (hold > 0) chk("resp_stable", 32'(bad), 32'd0);
        resp_ready[d] = 1'b1;
        @(posedge clk); #1 resp_ready[d] = 1'b0;
        chk("ready_after_hs", {30'd0, resp_valid[d], req_ready[d]}, 32'd1);
`ifdef RV32_CSR_PERF_COUNT_EN
        if (ill) exp_ill[d]++; else exp_ops[d]++;
`endif
    endtask

    initial begin
        logic [1:0] ptab [3];
        ptab[0] = 2'd0; ptab[1] = 2'd1; ptab[2] = 2'd3;
        for (int d = 0; d < 2; d++) begin
            priv[d] = 0; req_valid[d] = 0; req_funct3[d] = 0; req_addr[d] = 0;
            req_rs1[d] = 0; req_idx[d] = 0; req_rd[d] = 0; resp_ready[d] = 0;
            exp_addr[d] = 0; csr_val[d] = 0;
`ifdef RV32_CSR_PERF_COUNT_EN
            exp_ops[d] = 0; exp_ill[d] = 0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_outputs", {29'd0, resp_valid[d], csr_we[d], resp_ill[d]}, 32'd0);
            chk("rst_data", resp_data[d] | csr_wdata[d] | 32'(csr_addr[d]) | 32'(resp_rd[d]), 32'd0);
        end
        @(negedge clk) rst = 1'b1;

        run_op(0, 3'b001, 12'h340, 2'd3, 5'd7, 32'hDEADBEEF, 5'd5, 32'h1234, 0);
        run_op(0, 3'b010, 12'hC00, 2'd0, 5'd0, 32'hFFFFFFFF, 5'd6, 32'h55, 0);
        run_op(1, 3'b111, 12'h340, 2'd3, 5'd3, 32'h0, 5'd9, 32'hFF, 0);
        run_op(0, 3'b111, 12'h340, 2'd3, 5'd3, 32'h0, 5'd9, 32'hFF, 1);
        run_op(0, 3'b001, 12'hF11, 2'd3, 5'd1, 32'h1, 5'd4, 32'hABCD, 0);
        run_op(1, 3'b010, 12'h300, 2'd0, 5'd0, 32'h1, 5'd4, 32'hABCD, 0);
        run_op(1, 3'b001, 12'h305, 2'd3, 5'd2, 32'hA5A5A5A5, 5'd0, 32'h77, 5);
        run_op(0, 3'b100, 12'h340, 2'd3, 5'd2, 32'h1, 5'd1, 32'h77, 5);

        for (int k = 0; k < 60; k++) begin
            logic [11:0] a;
            logic [4:0]  ix;
            a  = {2'($urandom_range(3)), 2'($urandom_range(3)), 8'($urandom)};
            ix = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            run_op(k % 2, 3'($urandom), a, ptab[$urandom_range(2)], ix, $urandom,
                   5'($urandom), $urandom, $urandom_range(3));
        end

        // Reset asserted in the middle of the WRITE cycle.
        @(negedge clk);
        exp_addr[0] = 12'h340; csr_val[0] = 32'h1111; priv[0] = 2'd3;
        req_funct3[0] = 3'b001; req_addr[0] = 12'h340; req_rs1[0] = 32'h2222;
        req_idx[0] = 5'd1; req_rd[0] = 5'd3; req_valid[0] = 1'b1;
        @(posedge clk); #1 req_valid[0] = 1'b0;
        for (int i = 0; i < 10 && !csr_we[0]; i++) @(negedge clk);
        chk("mid_write_we", 32'(csr_we[0]), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_we", 32'(csr_we[0]), 32'd0);
        chk("rst_async_idle", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
        @(negedge clk) rst = 1'b1;
`ifdef RV32_CSR_PERF_COUNT_EN
        for (int d = 0; d < 2; d++) begin exp_ops[d] = 0; exp_ill[d] = 0; end
`endif
        @(negedge clk);
        chk("post_rst_ready", {29'd0, csr_we[0], resp_valid[0], req_ready[0]}, 32'd1);
        run_op(0, 3'b011, 12'h341, 2'd3, 5'd4, 32'h0000FF00, 5'd8, 32'h12345678, 0);
        run_op(1, 3'b110, 12'h100, 2'd1, 5'd16, 32'h0, 5'd2, 32'h1, 2);

`ifdef RV32_CSR_PERF_COUNT_EN
        for (int d = 0; d < 2; d++) begin
            chk("perf_ops", perf_ops[d], 32'(exp_ops[d]));
            chk("perf_ill", perf_ill[d], 32'(exp_ill[d]));
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32_csr_exec.md
Name: rv32_csr_exec

Overview:
Execute-stage CSR instruction unit for the rv32imc single-stage core. It accepts decoded CSRRW/CSRRS/CSRRC and their immediate forms from decode, and runs a read-modify-write sequence on the CSR file through its addr/data_in/data_out/write-strobe port. It checks access legality and returns the old CSR value for rd write-back through a valid/ready handshake.

Parameters:
READ_LATENCY, 0, CSR file read latency in cycles: 0 = async read, 1 = sync read.
XLEN, 32, data width.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low
priviledge  in  2  current privilege mode (0=U, 1=S, 3=M)
req_valid  in  1  decoded CSR instruction present
req_ready  out  1  unit can accept a request
req_funct3  in  3  instr[14:12]
req_csr_addr  in  12  CSR address
req_rs1_data  in  XLEN  rs1 value
req_rs1_idx  in  5  rs1 index, or uimm in immediate forms
req_rd_idx  in  5  destination register
csr_addr  out  12  address to CSR file
csr_wdata  out  XLEN  write data to CSR file
csr_we  out  1  CSR file write strobe (drives cas_oder_so)
csr_rdata  in  XLEN  CSR file read data
resp_valid  out  1  result available
resp_ready  in  1  write-back accepts result
resp_rd_idx  out  5  destination register
resp_rd_data  out  XLEN  old CSR value (0 if illegal)
resp_illegal  out  1  illegal-instruction exception flag

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset state is IDLE, and every register clears to 0. After reset: req_ready=1, resp_valid=0, csr_we=0, all data outputs 0.
- IDLE: req_ready=1. On req_valid, latch all request fields.
  - Illegal request -> RESP with resp_illegal=1 and resp_rd_data=0.
  - Otherwise -> READ.
- Illegal when any of these holds:
  - funct3 is 000 or 100;
  - csr_addr[9:8] > priviledge;
  - csr_addr[11:10]==2'b11 and a write is required.
- Write required:
  - CSRRW/CSRRWI: always.
  - CSRRS/CSRRC/CSRRSI/CSRRCI: only when req_rs1_idx != 0.
- READ: csr_addr is driven from the latch, and an internal counter waits READ_LATENCY cycles. Old value is sampled from csr_rdata on the last READ cycle. Next state is WRITE if a write is required, else RESP.
- Source operand: funct3[2] ? {27'b0, rs1_idx} : rs1_data.
- Write data:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- WRITE: exactly one cycle with csr_we=1, csr_addr and csr_wdata stable -> RESP.
- csr_we is 0 in every state except WRITE. csr_addr holds the latched address from READ until the return to IDLE.
- RESP: resp_valid=1 with stable rd_idx, rd_data and illegal until resp_ready. On handshake -> IDLE. req_ready=0 in READ, WRITE and RESP (no overlap).
- Latency: READ_LATENCY=0 gives accept T0, READ T1, WRITE T2, resp_valid T3. Each extra latency cycle adds 1.
- rd_idx==0: the sequence runs normally; write-back discards the result.
- Asynchronous reset mid-sequence returns to IDLE immediately and drops csr_we the same instant. A partially-issued write is never completed.

Optional Feature:
RV32_CSR_PERF_COUNT_EN
- Defined: adds outputs perf_csr_ops[31:0] and perf_illegal[31:0].
  - perf_csr_ops increments on each legal RESP handshake; perf_illegal increments on each illegal one.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package rv32_csr_pkg holds:
  - csr_op_e enum (RW/RS/RC with immediate flag);
  - funct3 constants;
  - address field slice constants (permission [11:10], privilege [9:8]);
  - privilege-level constants.
- Sub-module rv32_csr_legal_check: combinational illegal/write-required decode. It is reusable by the future trap unit.

Test Plan:
- CSRRW x5, 0x340, rs1=0xDEADBEEF, M-mode, CSR old=0x1234 -> one csr_we pulse with wdata 0xDEADBEEF; resp rd_data=0x1234, illegal=0.
- CSRRS rs1=x0 on 0xC00 in U-mode, old=0x55 -> csr_we never asserts; rd_data=0x55.
- CSRRCI uimm=0x3, old=0xFF -> wdata=0xFC. With READ_LATENCY=1, resp_valid appears on T4.
- CSRRW to 0xF11 (read-only) -> resp_illegal=1, rd_data=0, no csr_we. Access to 0x300 from priviledge=0 -> illegal.
- resp_ready held low 5 cycles -> resp_valid and data stable, req_ready=0. New request accepted the cycle after the handshake.
- rst asserted during WRITE -> csr_we drops asynchronously; FSM in IDLE with req_ready=1 after release.
